// File: rtl/hex_digit_scanner_if.sv
// Bundle of the scanner's value/load/blank inputs and its display-side
// outputs. The master modport is the producer of values (for example a
// register bank). The slave modport is the scanner itself.
interface hex_digit_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    load;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [3:0]              nibble_out;
  logic [NUM_DIGITS-1:0]   digit_en_n;
  logic [2:0]              digit_idx;
  logic                    frame_done;

  modport master (
    output value_in, load, blank_mask,
    input  nibble_out, digit_en_n, digit_idx, frame_done
  );

  modport slave (
    input  value_in, load, blank_mask,
    output nibble_out, digit_en_n, digit_idx, frame_done
  );
endinterface

// File: rtl/hex_digit_scanner.sv
// Time-multiplexed hex digit scanner feeding a seven-segment decoder.
//
// A shadow register is loaded from value_in. It is copied into the active
// register only at a frame boundary, so a displayed frame never tears.
// Each digit owns REFRESH_DIV cycles. The first DEAD_CYCLES cycles of each
// slot keep every enable off to avoid ghosting.
//
// The display stays dark after reset until the first commit. Because of
// this, stale or zero data is never shown before a real value arrives.
//
// Optional feature: define LEADING_ZERO_SUPPRESS_EN to darken digits above
// the most significant nonzero active digit. Digit 0 always stays lit.
module hex_digit_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 16
) (
  input logic               clk,
  input logic               rst_n,
  hex_digit_scanner_if.slave bus
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int CW = $clog2(REFRESH_DIV + 1);

  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [2:0]            idx_reg, idx_next;
  logic [W-1:0]          shadow_reg, shadow_next;
  logic [W-1:0]          active_reg, active_next;
  logic                  pending_reg, pending_next;
  logic                  shown_reg, shown_next;
  logic [3:0]            nibble_reg, nibble_next;
  logic [NUM_DIGITS-1:0] en_n_reg, en_n_next;
  logic                  frame_done_reg;

  logic                  slot_end;
  logic                  frame_end;
  logic                  in_window;
  logic [3:0]            digit_next [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lzs;
  logic [NUM_DIGITS-1:0] dark;

  // Slot/frame sequencing and double-buffered value commit
  always_comb begin
    slot_end     = (cnt_reg == CW'(REFRESH_DIV - 1));
    frame_end    = slot_end && (idx_reg == 3'(NUM_DIGITS - 1));
    cnt_next     = slot_end ? '0 : cnt_reg + CW'(1);
    idx_next     = frame_end ? 3'd0 : (slot_end ? idx_reg + 3'd1 : idx_reg);
    shadow_next  = bus.load ? bus.value_in : shadow_reg;
    active_next  = active_reg;
    pending_next = pending_reg;
    shown_next   = shown_reg;
    if (frame_end && bus.load) begin
      // A load on the last cycle of the frame goes straight to the display.
      active_next  = bus.value_in;
      pending_next = 1'b0;
      shown_next   = 1'b1;
    end else if (frame_end && pending_reg) begin
      active_next  = shadow_reg;
      pending_next = 1'b0;
      shown_next   = 1'b1;
    end else if (bus.load) begin
      pending_next = 1'b1;
    end
  end

  // Split the upcoming active value into nibbles and compute per-digit suppression
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign digit_next[gi] = active_next[4*gi +: 4];
`ifdef LEADING_ZERO_SUPPRESS_EN
    if (gi == 0) begin : g_keep
      assign lzs[gi] = 1'b0;
    end else begin : g_sup
      assign lzs[gi] = ~|active_next[W-1:4*gi];
    end
`else
    assign lzs[gi] = 1'b0;
`endif
  end

  assign dark = bus.blank_mask | lzs;

  // The enable window begins after the dead time of the upcoming slot cycle
  if (DEAD_CYCLES == 0) begin : g_no_dead
    assign in_window = 1'b1;
  end else begin : g_dead
    assign in_window = (cnt_next >= CW'(DEAD_CYCLES));
  end

  // Output values for the upcoming cycle: selected nibble and at most one enable low
  always_comb begin
    nibble_next = 4'd0;
    en_n_next   = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_next == 3'(k)) begin
        nibble_next = digit_next[k];
        if (in_window && shown_next && !dark[k]) begin
          en_n_next[k] = 1'b0;
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      idx_reg        <= 3'd0;
      shadow_reg     <= '0;
      active_reg     <= '0;
      pending_reg    <= 1'b0;
      shown_reg      <= 1'b0;
      nibble_reg     <= 4'd0;
      en_n_reg       <= '1;
      frame_done_reg <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      shadow_reg     <= shadow_next;
      active_reg     <= active_next;
      pending_reg    <= pending_next;
      shown_reg      <= shown_next;
      nibble_reg     <= nibble_next;
      en_n_reg       <= en_n_next;
      frame_done_reg <= frame_end;
    end
  end

  assign bus.nibble_out = nibble_reg;
  assign bus.digit_en_n = en_n_reg;
  assign bus.digit_idx  = idx_reg;
  assign bus.frame_done = frame_done_reg;
endmodule

// File: tb/tb_hex_digit_scanner.sv
// Directed testbench for hex_digit_scanner with NUM_DIGITS=4,
// REFRESH_DIV=8 and DEAD_CYCLES=2. The frame is 32 cycles long.
// The time t counts rising edges since the last reset release.
// A frame boundary falls on every t that is a multiple of 32.
module tb_hex_digit_scanner;
  logic clk;
  logic rst_n;
  int   t;
  int   tests;
  int   fails;

  hex_digit_scanner_if #(.NUM_DIGITS(4)) bus ();

  hex_digit_scanner #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(8),
    .DEAD_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("[TB] t=%0d %s observed %h expected %h", t, tag, obs, exp);
  endtask

  task automatic goto(input int target);
    while (t < target) begin
      @(posedge clk);
      @(negedge clk);
      t++;
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.value_in = v;
    bus.load     = 1'b1;
    goto(t + 1);
    bus.load     = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    t     = 0;
    rst_n = 1'b0;
    bus.value_in   = 16'h0;
    bus.load       = 1'b0;
    bus.blank_mask = 4'b0000;
    repeat (2) @(negedge clk);
    chk("rst_en", 16'(bus.digit_en_n), 16'hF);
    chk("rst_nib", 16'(bus.nibble_out), 16'h0);
    chk("rst_idx", 16'(bus.digit_idx), 16'h0);
    chk("rst_fd", 16'(bus.frame_done), 16'h0);
    rst_n = 1'b1;

    // Load 1A2F. The commit happens at t=32. The display stays dark until then.
    do_load(16'h1A2F);
    goto(20);
    chk("t1_dark_en", 16'(bus.digit_en_n), 16'hF);
    chk("t1_idx20", 16'(bus.digit_idx), 16'h2);
    goto(31);
    chk("t1_fd31", 16'(bus.frame_done), 16'h0);
    goto(32);
    chk("t1_fd32", 16'(bus.frame_done), 16'h1);
    chk("t1_nib_s0", 16'(bus.nibble_out), 16'hF);
    chk("t1_en_c0", 16'(bus.digit_en_n), 16'hF);
    goto(33);
    chk("t1_fd33", 16'(bus.frame_done), 16'h0);
    chk("t1_en_c1", 16'(bus.digit_en_n), 16'hF);
    goto(34);
    chk("t1_en_c2", 16'(bus.digit_en_n), 16'hE);
    goto(39);
    chk("t1_en_c7", 16'(bus.digit_en_n), 16'hE);
    goto(40);
    chk("t1_nib_s1", 16'(bus.nibble_out), 16'h2);
    chk("t1_idx_s1", 16'(bus.digit_idx), 16'h1);
    chk("t1_en_s1c0", 16'(bus.digit_en_n), 16'hF);
    goto(42);
    chk("t1_en_s1c2", 16'(bus.digit_en_n), 16'hD);
    goto(48);
    chk("t1_nib_s2", 16'(bus.nibble_out), 16'hA);
    goto(56);
    chk("t1_nib_s3", 16'(bus.nibble_out), 16'h1);
    goto(58);
    chk("t1_en_s3c2", 16'(bus.digit_en_n), 16'h7);
    goto(64);
    chk("t1_fd64", 16'(bus.frame_done), 16'h1);
    chk("t1_nib64", 16'(bus.nibble_out), 16'hF);

    // Load 1234, which commits at t=96. A mid-frame load of 5678 must not tear the frame.
    do_load(16'h1234);
    goto(96);
    chk("t2_nib_s0", 16'(bus.nibble_out), 16'h4);
    goto(104);
    chk("t2_nib_s1", 16'(bus.nibble_out), 16'h3);
    goto(112);
    do_load(16'h5678);
    chk("t2_nib_s2c1", 16'(bus.nibble_out), 16'h2);
    goto(120);
    chk("t2_nib_s3", 16'(bus.nibble_out), 16'h1);
    goto(128);
    chk("t2_fd128", 16'(bus.frame_done), 16'h1);
    chk("t2_nib_n0", 16'(bus.nibble_out), 16'h8);
    goto(136);
    chk("t2_nib_n1", 16'(bus.nibble_out), 16'h7);
    goto(144);
    chk("t2_nib_n2", 16'(bus.nibble_out), 16'h6);
    goto(152);
    chk("t2_nib_n3", 16'(bus.nibble_out), 16'h5);

    // A load on the last cycle of slot 3 commits directly at the boundary.
    goto(159);
    do_load(16'hBEEF);
    chk("t3_nib_s0", 16'(bus.nibble_out), 16'hF);
    chk("t3_fd", 16'(bus.frame_done), 16'h1);
    chk("t3_pending", 16'(dut.pending_reg), 16'h0);
    goto(168);
    chk("t3_nib_s1", 16'(bus.nibble_out), 16'hE);
    goto(184);
    chk("t3_nib_s3", 16'(bus.nibble_out), 16'hB);

    // blank_mask=0100 with value 1234, committed at t=192
    do_load(16'h1234);
    bus.blank_mask = 4'b0100;
    goto(194);
    chk("t4_nib_s0", 16'(bus.nibble_out), 16'h4);
    chk("t4_en_s0", 16'(bus.digit_en_n), 16'hE);
    goto(202);
    chk("t4_en_s1", 16'(bus.digit_en_n), 16'hD);
    goto(210);
    chk("t4_nib_s2", 16'(bus.nibble_out), 16'h2);
    chk("t4_en_s2", 16'(bus.digit_en_n), 16'hF);
    goto(215);
    chk("t4_en_s2c7", 16'(bus.digit_en_n), 16'hF);
    goto(218);
    chk("t4_en_s3", 16'(bus.digit_en_n), 16'h7);
    goto(221);
    bus.blank_mask = 4'b1000;
    goto(222);
    chk("t4_blank_next", 16'(bus.digit_en_n), 16'hF);
    bus.blank_mask = 4'b0000;

    // Value 0050, which commits at t=224, then value 0000, which commits at t=256
    do_load(16'h0050);
    goto(226);
    chk("t5_nib_s0", 16'(bus.nibble_out), 16'h0);
    chk("t5_en_s0", 16'(bus.digit_en_n), 16'hE);
    goto(234);
    chk("t5_nib_s1", 16'(bus.nibble_out), 16'h5);
    chk("t5_en_s1", 16'(bus.digit_en_n), 16'hD);
    goto(242);
`ifdef LEADING_ZERO_SUPPRESS_EN
    chk("t5_en_s2", 16'(bus.digit_en_n), 16'hF);
`else
    chk("t5_en_s2", 16'(bus.digit_en_n), 16'hB);
`endif
    goto(250);
`ifdef LEADING_ZERO_SUPPRESS_EN
    chk("t5_en_s3", 16'(bus.digit_en_n), 16'hF);
`else
    chk("t5_en_s3", 16'(bus.digit_en_n), 16'h7);
`endif
    do_load(16'h0000);
    goto(258);
    chk("t5_zero_nib", 16'(bus.nibble_out), 16'h0);
    chk("t5_zero_en0", 16'(bus.digit_en_n), 16'hE);
    goto(265);
    // Leave a load pending. The reset below must discard it.
    do_load(16'hABCD);
`ifdef LEADING_ZERO_SUPPRESS_EN
    chk("t5_zero_en1", 16'(bus.digit_en_n), 16'hF);
`else
    chk("t5_zero_en1", 16'(bus.digit_en_n), 16'hD);
`endif

    // Reset asserted during slot 1, cycle 5
    goto(269);
    chk("t6_pre_idx", 16'(bus.digit_idx), 16'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_en", 16'(bus.digit_en_n), 16'hF);
    chk("t6_async_nib", 16'(bus.nibble_out), 16'h0);
    chk("t6_async_idx", 16'(bus.digit_idx), 16'h0);
    @(negedge clk);
    chk("t6_pending", 16'(dut.pending_reg), 16'h0);
    rst_n = 1'b1;
    t = 0;
    for (int i = 1; i <= 31; i++) begin
      goto(i);
      chk("t6_fd_quiet", 16'(bus.frame_done), 16'h0);
      chk("t6_dark", 16'(bus.digit_en_n), 16'hF);
    end
    goto(32);
    chk("t6_fd32", 16'(bus.frame_done), 16'h1);
    chk("t6_idx32", 16'(bus.digit_idx), 16'h0);
    goto(34);
    chk("t6_still_dark", 16'(bus.digit_en_n), 16'hF);
    do_load(16'h1A2F);
    goto(66);
    chk("t6_relit_nib", 16'(bus.nibble_out), 16'hF);
    chk("t6_relit_en", 16'(bus.digit_en_n), 16'hE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
